// File: rtl/prog_seq_pkg.sv
// Package for the program sequencer.
// Holds the FSM state type, the default parameter values and a helper that
// sizes slot indices. Optional feature macro used by the top:
// PROG_SEQ_STOP_ON_ERR_EN (see prog_sequencer.sv).
package prog_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      ABORT  = 2'd3
   } prog_seq_state_e;

   localparam int DEF_NUM_PROGS      = 3;
   localparam int DEF_PC_W           = 10;
   localparam int DEF_START_CYCLES   = 2;
   localparam int DEF_TIMEOUT_CYCLES = 65535;
   localparam int DEF_CNT_W          = 16;

   // Slot index width; a single-slot table still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_sequencer_table.sv
// prog_entry_table: NUM_PROGS x PC_W entry-PC register file.
// Ports:
//   CLK, rst_n      clock, asynchronous active-low reset (clears every slot)
//   we, widx, wdata single write port; writes to a slot >= NUM_PROGS are dropped
//   ridx, rdata     combinational read port; an out-of-range slot reads 0
module prog_entry_table
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS = DEF_NUM_PROGS,
   parameter int PC_W      = DEF_PC_W,
   parameter int IDX_W     = idx_w(DEF_NUM_PROGS)
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [PC_W-1:0]  wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic [PC_W-1:0]  rdata
);

   localparam logic [IDX_W:0] NP = (IDX_W + 1)'(NUM_PROGS);

   logic [PC_W-1:0] mem [NUM_PROGS];

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PROGS; i++) mem[i] <= '0;
      end else if (we && ({1'b0, widx} < NP)) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = ({1'b0, ridx} < NP) ? mem[ridx] : '0;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs a batch of core test programs back-to-back.
// Each launch holds core_start high for START_CYCLES with the slot's entry PC
// presented, then releases the core and counts RUN cycles until an armed halt
// or a timeout.
// Core handshake: core_start=1 keeps the core in start; its falling edge
// launches the program at core_entry_pc. core_halt is a level; it completes
// a program only after it has been seen low at least once in that RUN, so a
// halt left over from the previous program is never mistaken for completion.
// Ports:
//   CLK, rst_n                  clock, asynchronous active-low reset
//   go, num_progs               batch start (IDLE only), batch size (0/too big -> all)
//   cfg_we, cfg_idx, cfg_pc     entry table write (IDLE only)
//   core_start, core_entry_pc   to the core
//   core_halt                   from the core
//   busy, cur_prog              LAUNCH/RUN indicator, active slot
//   prog_done, prog_cycles      per-program completion pulse and RUN-cycle count
//   batch_done, err             end-of-batch pulse, sticky timeout flag
//   dbg_state                   current FSM state
// Macro PROG_SEQ_STOP_ON_ERR_EN: defined -> a timeout ends the batch through
// ABORT; undefined -> a timeout flags err and moves on to the next slot.
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS      = DEF_NUM_PROGS,
   parameter int PC_W           = DEF_PC_W,
   parameter int START_CYCLES   = DEF_START_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W,
   localparam int IDX_W         = idx_w(NUM_PROGS)
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             go,
   input  logic [IDX_W:0]   num_progs,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [PC_W-1:0]  cfg_pc,
   output logic             core_start,
   output logic [PC_W-1:0]  core_entry_pc,
   input  logic             core_halt,
   output logic             busy,
   output logic [IDX_W-1:0] cur_prog,
   output logic             prog_done,
   output logic [CNT_W-1:0] prog_cycles,
   output logic             batch_done,
   output logic             err,
   output prog_seq_state_e  dbg_state
);

   localparam logic [IDX_W:0]   NP_MAX  = (IDX_W + 1)'(NUM_PROGS);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);

   prog_seq_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [IDX_W-1:0] cur_q, cur_d, last_q, last_d;
   logic [IDX_W:0]   num_eff;
   logic             armed_q, armed_d, err_q, err_d;
   logic             pdone_q, pdone_d, bdone_q, bdone_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [PC_W-1:0]  entry_q, entry_d, tbl_rdata;
   logic             tbl_we, end_prog;

   prog_entry_table #(
      .NUM_PROGS(NUM_PROGS),
      .PC_W     (PC_W),
      .IDX_W    (IDX_W)
   ) u_table (
      .CLK  (CLK),
      .rst_n(rst_n),
      .we   (tbl_we),
      .widx (cfg_idx),
      .wdata(cfg_pc),
      .ridx (cur_q),
      .rdata(tbl_rdata)
   );

   // cnt is shared: it times the LAUNCH hold, then counts RUN cycles.
   // cnt_inc is the count including the current RUN cycle.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign num_eff = ((num_progs == '0) || (num_progs > NP_MAX)) ? NP_MAX : num_progs;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cur_d         = cur_q;
      last_d        = last_q;
      armed_d       = armed_q;
      err_d         = err_q;
      cyc_d         = cyc_q;
      entry_d       = entry_q;
      pdone_d       = 1'b0;
      bdone_d       = 1'b0;
      tbl_we        = 1'b0;
      end_prog      = 1'b0;
      core_start    = 1'b1;
      busy          = 1'b0;
      core_entry_pc = entry_q;
      case (state_q)
         IDLE: begin
            // Table write lands at the same edge go is taken, so LAUNCH
            // (which reads the table) sees the new value.
            tbl_we = cfg_we;
            if (go) begin
               state_d = LAUNCH;
               cur_d   = '0;
               last_d  = IDX_W'(num_eff - 1'b1);
               err_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         LAUNCH: begin
            busy          = 1'b1;
            core_entry_pc = tbl_rdata;
            entry_d       = tbl_rdata;
            armed_d       = 1'b0;
            if (cnt_q == ST_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            core_start = 1'b0;
            busy       = 1'b1;
            cnt_d      = cnt_inc;
            if (!core_halt) armed_d = 1'b1;
            // Armed halt takes priority over a timeout in the same cycle.
            if (core_halt && armed_q) begin
               cyc_d    = cnt_inc;
               pdone_d  = 1'b1;
               end_prog = 1'b1;
            end else if (cnt_inc >= TO_LIM) begin
               cyc_d = cnt_inc;
               err_d = 1'b1;
`ifdef PROG_SEQ_STOP_ON_ERR_EN
               state_d = ABORT;
               bdone_d = 1'b1;
`else
               end_prog = 1'b1;
`endif
            end
            if (end_prog) begin
               if (cur_q == last_q) begin
                  state_d = IDLE;
                  bdone_d = 1'b1;
               end else begin
                  state_d = LAUNCH;
                  cur_d   = cur_q + 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         ABORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         cur_q   <= '0;
         last_q  <= '0;
         armed_q <= 1'b0;
         err_q   <= 1'b0;
         cyc_q   <= '0;
         entry_q <= '0;
         pdone_q <= 1'b0;
         bdone_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         armed_q <= armed_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         entry_q <= entry_d;
         pdone_q <= pdone_d;
         bdone_q <= bdone_d;
      end
   end

   assign cur_prog    = cur_q;
   assign prog_done   = pdone_q;
   assign prog_cycles = cyc_q;
   assign batch_done  = bdone_q;
   assign err         = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus randomized batches,
// checked against a transaction-level model of expected program outcomes.
module tb_prog_sequencer;
   import prog_seq_pkg::*;

   localparam int NP = 3, PCW = 10, SC = 2, TO = 100, CW = 16;
`ifdef PROG_SEQ_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   logic            go = 1'b0, cfg_we = 1'b0, core_halt = 1'b0;
   logic [2:0]      num_progs = '0;
   logic [1:0]      cfg_idx = '0;
   logic [PCW-1:0]  cfg_pc = '0;
   logic            core_start, busy, prog_done, batch_done, err;
   logic [PCW-1:0]  core_entry_pc;
   logic [1:0]      cur_prog;
   logic [CW-1:0]   prog_cycles;
   prog_seq_state_e dbg_state;

   prog_sequencer #(
      .NUM_PROGS(NP), .PC_W(PCW), .START_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
   ) dut (
      .CLK(CLK), .rst_n(rst_n), .go(go), .num_progs(num_progs),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
      .core_start(core_start), .core_entry_pc(core_entry_pc), .core_halt(core_halt),
      .busy(busy), .cur_prog(cur_prog), .prog_done(prog_done),
      .prog_cycles(prog_cycles), .batch_done(batch_done), .err(err),
      .dbg_state(dbg_state)
   );

   // ---------------- model state ----------------
   typedef struct packed {
      logic [PCW-1:0] pc;
      logic [1:0]     slot;
      logic           done;
      logic [CW-1:0]  cycles;
      logic           err;
      logic           bdone;
   } exp_t;
   typedef struct packed {
      int stale;    // RUN cycles with halt held high from the previous program
      int halt_at;  // RUN cycle where halt rises, 0 = never
   } plan_t;

   exp_t           exp_q[$];
   plan_t          plan_q[$];
   plan_t          plan_arr[NP];
   logic [PCW-1:0] tbl_m[NP];
   logic [CW-1:0]  obs_cycles[$];
   logic [PCW-1:0] obs_pc[$];
   int  n_cmp = 0, n_err = 0, bd_cnt = 0;
   bit  first_pending = 1'b0;
   int  go_cyc = 0, end_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- core model ----------------
   int    run_k = 0;
   plan_t cur_plan = '0;
   always @(negedge CLK) begin
      if (!rst_n) begin
         run_k     = 0;
         core_halt = 1'b0;
      end else if (!core_start) begin
         run_k++;
         if (run_k == 1) cur_plan = (plan_q.size() > 0) ? plan_q.pop_front() : '0;
         core_halt = (run_k <= cur_plan.stale) ||
                     (cur_plan.halt_at != 0 && run_k >= cur_plan.halt_at);
      end else begin
         run_k = 0;
      end
   end

   // ---------------- compare process ----------------
   logic prev_start = 1'b1;
   always @(negedge CLK) begin
      if (!rst_n) begin
         prev_start = 1'b1;
      end else begin
         if (prev_start && !core_start) begin
            if (exp_q.size() == 0) chk("unexpected_launch", 1, 0);
            else begin
               chk("launch_pc", core_entry_pc, exp_q[0].pc);
               chk("launch_slot", cur_prog, exp_q[0].slot);
               chk("launch_busy", busy, 1);
               obs_pc.push_back(core_entry_pc);
               if (first_pending) chk("go_latency", cyc - go_cyc, 1 + SC);
               else               chk("launch_gap", cyc - end_cyc, SC);
               first_pending = 1'b0;
            end
         end else if (!prev_start && core_start) begin
            if (exp_q.size() == 0) chk("unexpected_run_end", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("prog_done", prog_done, e.done);
               chk("prog_cycles", prog_cycles, e.cycles);
               chk("err", err, e.err);
               chk("batch_done", batch_done, e.bdone);
               if (prog_done) obs_cycles.push_back(prog_cycles);
               end_cyc = cyc;
            end
         end else begin
            chk("stray_prog_done", prog_done, 0);
            chk("stray_batch_done", batch_done, 0);
         end
         if (batch_done) bd_cnt++;
         prev_start = core_start;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_vals(input string tag);
      chk({tag, "_core_start"}, core_start, 1);
      chk({tag, "_entry_pc"}, core_entry_pc, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cur_prog"}, cur_prog, 0);
      chk({tag, "_prog_done"}, prog_done, 0);
      chk({tag, "_prog_cycles"}, prog_cycles, 0);
      chk({tag, "_batch_done"}, batch_done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_state"}, dbg_state, IDLE);
   endtask

   task automatic cfg_write(input int idx, input logic [PCW-1:0] pc);
      cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_pc = pc;
      if (idx < NP) tbl_m[idx] = pc;
      @(negedge CLK); #1;
      cfg_we = 1'b0;
   endtask

   // Builds the expected outcome of each program from the plans and the
   // table, then issues go (optionally with a same-cycle table write).
   task automatic start_batch(input logic [2:0] np, input bit with_cfg,
                              input int cidx, input logic [PCW-1:0] cpc);
      int   n;
      logic err_acc;
      err_acc = 1'b0;
      if (with_cfg) begin
         cfg_we = 1'b1; cfg_idx = cidx[1:0]; cfg_pc = cpc;
         if (cidx < NP) tbl_m[cidx] = cpc;
      end
      n = (np == 0 || np > NP) ? NP : int'(np);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         bit   tmo;
         tmo     = (plan_arr[i].halt_at == 0) || (plan_arr[i].halt_at > TO);
         e.pc    = tbl_m[i];
         e.slot  = i[1:0];
         e.done  = !tmo;
         e.cycles = tmo ? CW'(TO) : CW'(plan_arr[i].halt_at);
         err_acc = err_acc | tmo;
         e.err   = err_acc;
         e.bdone = (i == n - 1) || (tmo && STOP);
         exp_q.push_back(e);
         plan_q.push_back(plan_arr[i]);
         if (tmo && STOP) break;
      end
      go = 1'b1; num_progs = np; go_cyc = cyc; first_pending = 1'b1;
      @(negedge CLK); #1;
      go = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic wait_batch(input string tag);
      int t0, c;
      t0 = bd_cnt; c = 0;
      while (bd_cnt == t0 && c < 3000) begin
         @(negedge CLK); #1;
         c++;
      end
      chk({tag, "_batch_done_seen"}, bd_cnt - t0, 1);
      chk({tag, "_exp_left"}, exp_q.size(), 0);
      chk({tag, "_busy_after"}, busy, 0);
      exp_q.delete();
      plan_q.delete();
      @(negedge CLK); #1;   // ABORT, if any, has returned to IDLE
   endtask

   task automatic wait_run_start(input string tag);
      int c;
      c = 0;
      while (core_start && c < 200) begin
         @(negedge CLK); #1;
         c++;
      end
      chk({tag, "_run_reached"}, core_start, 0);
   endtask

   task automatic set_plan(input int i, input int stale, input int halt_at);
      plan_arr[i].stale   = stale;
      plan_arr[i].halt_at = halt_at;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < NP; i++) tbl_m[i] = '0;
      repeat (3) @(negedge CLK);
      #1;
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      @(negedge CLK); #1;
      check_reset_vals("after_reset");

      // Three programs from a configured table.
      cfg_write(0, 10'h000); cfg_write(1, 10'h040); cfg_write(2, 10'h080);
      set_plan(0, 0, 20); set_plan(1, 0, 35); set_plan(2, 0, 50);
      obs_cycles.delete(); obs_pc.delete();
      start_batch(3'd3, 1'b0, 0, '0);
      wait_batch("basic");
      chk("basic_ndone", obs_cycles.size(), 3);
      if (obs_cycles.size() == 3) begin
         chk("basic_cyc0", obs_cycles[0], 20);
         chk("basic_cyc1", obs_cycles[1], 35);
         chk("basic_cyc2", obs_cycles[2], 50);
      end
      if (obs_pc.size() == 3) begin
         chk("basic_pc1", obs_pc[1], 10'h040);
         chk("basic_pc2", obs_pc[2], 10'h080);
      end
      chk("basic_err", err, 0);

      // Halt still high from the previous program for three RUN cycles.
      set_plan(0, 3, 10);
      start_batch(3'd1, 1'b0, 0, '0);
      wait_batch("stale");
      chk("stale_cycles", prog_cycles, 10);

      // Timeout on slot 0, slot 1 halts normally.
      set_plan(0, 0, 0); set_plan(1, 0, 15);
      start_batch(3'd2, 1'b0, 0, '0);
      wait_batch("timeout");
      chk("timeout_err", err, 1);
      chk("timeout_cycles", prog_cycles, STOP ? 100 : 15);

      // go and cfg_we during RUN are ignored; err clears on the next go.
      set_plan(0, 0, 30); set_plan(1, 0, 30);
      start_batch(3'd2, 1'b0, 0, '0);
      chk("clear_err_on_go", err, 0);
      wait_run_start("busy_go");
      repeat (4) @(negedge CLK);
      #1;
      go = 1'b1; num_progs = 3'd1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pc = 10'h3ff;
      @(negedge CLK); #1;
      go = 1'b0; cfg_we = 1'b0;
      wait_batch("busy_go");
      obs_pc.delete();
      set_plan(0, 0, 12); set_plan(1, 0, 13);
      start_batch(3'd2, 1'b0, 0, '0);
      wait_batch("tbl_kept");
      if (obs_pc.size() == 2) chk("tbl_kept_pc1", obs_pc[1], 10'h040);
      else                    chk("tbl_kept_nlaunch", obs_pc.size(), 2);

      // Write and go in the same IDLE cycle.
      obs_pc.delete();
      set_plan(0, 0, 8);
      start_batch(3'd1, 1'b1, 0, 10'h155);
      wait_batch("cfg_go");
      if (obs_pc.size() == 1) chk("cfg_go_pc", obs_pc[0], 10'h155);
      else                    chk("cfg_go_nlaunch", obs_pc.size(), 1);

      // num_progs = 0 runs every slot.
      obs_cycles.delete();
      set_plan(0, 0, 5); set_plan(1, 0, 6); set_plan(2, 0, 7);
      start_batch(3'd0, 1'b0, 0, '0);
      wait_batch("np_zero");
      chk("np_zero_ndone", obs_cycles.size(), 3);

      // Randomized batches.
      for (int b = 0; b < 8; b++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, NP - 1), PCW'($urandom));
         for (int i = 0; i < NP; i++) begin
            int st, ha;
            st = $urandom_range(0, 2);
            ha = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(st + 2, 60);
            set_plan(i, st, ha);
         end
         start_batch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, NP - 1), PCW'($urandom));
         wait_batch("rand");
      end

      // Asynchronous reset at RUN cycle 7.
      set_plan(0, 0, 0);
      start_batch(3'd1, 1'b0, 0, '0);
      wait_run_start("rst_mid");
      repeat (6) @(negedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      exp_q.delete(); plan_q.delete();
      for (int i = 0; i < NP; i++) tbl_m[i] = '0;
      @(negedge CLK); #1;
      rst_n = 1'b1;
      @(negedge CLK); #1;
      obs_pc.delete();
      set_plan(0, 0, 6); set_plan(1, 0, 7); set_plan(2, 0, 8);
      start_batch(3'd3, 1'b0, 0, '0);
      wait_batch("after_rst");
      chk("after_rst_nlaunch", obs_pc.size(), 3);
      if (obs_pc.size() == 3) chk("after_rst_pc1", obs_pc[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
